// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and pattern helper for the RAM BIST controller
//
// Purpose: FSM state encoding and the expected-data function used by both the
//          pattern generator (top) and the read-back comparator.
// Contents:
//   bist_state_e  controller FSM states
//   exp_pat()     expected word for an address; the caller truncates to DATA_WIDTH,
//                 which gives the modulo-2**DATA_WIDTH wrap for free

package ram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      WRITE_INV,
      READ_INV,
      DRAIN,
      DONE
   } bist_state_e;

   // Truncating (addr + ofs) later is identical to truncating addr first and then
   // adding ofs, so the sum is formed at full width here. Inversion commutes with
   // truncation as well.
   function automatic logic [31:0] exp_pat(input logic [31:0] addr,
                                           input logic        inv,
                                           input logic [31:0] ofs);
      logic [31:0] p;
      p = addr + ofs;
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - single-port RAM port bundle between BIST controller and RAM
//
// Purpose: groups the RAM's data/addr/we/q port so the controller takes it as one port.
// Signals:
//   data  DATA_WIDTH  write data to RAM
//   addr  ADDR_WIDTH  address to RAM
//   we    1           write enable to RAM
//   q     DATA_WIDTH  read data from RAM
// Modports:
//   master  controller side (drives data/addr/we, samples q)
//   slave   RAM side

interface ram_bist_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [DATA_WIDTH-1:0] q;

   modport master (output data, output addr, output we, input q);
   modport slave  (input data, input addr, input we, output q);
endinterface

// File: rtl/ram_bist_cmp.sv
// rtl/ram_bist_cmp.sv - read-back delay line, comparator and error accounting
//
// Purpose: delays each issued read {valid, inv, addr} by RD_LAT clocks so it lines up
//          with ram_q, compares against the expected pattern, counts mismatches
//          (saturating) and latches the address of the first one.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             clear err_cnt/first_err_addr (test start)
//   iss_vld         a read is being presented to the RAM this cycle
//   iss_inv         that read belongs to the inverted pass
//   iss_addr        address of that read
//   ram_q           RAM read data
//   err_cnt         registered mismatch count, saturates at all-ones
//   first_err_addr  registered address of the first mismatch, 0 if none

module ram_bist_cmp
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned PAT_OFS    = 1,
   parameter int unsigned ERR_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  iss_vld,
   input  logic                  iss_inv,
   input  logic [ADDR_WIDTH-1:0] iss_addr,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [ERR_W-1:0]      err_cnt,
   output logic [ADDR_WIDTH-1:0] first_err_addr
);

   logic [RD_LAT-1:0]                 vld_q, vld_d;
   logic [RD_LAT-1:0]                 inv_q, inv_d;
   logic [RD_LAT-1:0][ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [ERR_W-1:0]                  err_q, err_d;
   logic [ADDR_WIDTH-1:0]             fea_q, fea_d;
   logic [DATA_WIDTH-1:0]             exp_word;
   logic                              mismatch;

   // Stage RD_LAT-1 describes the read whose data is on ram_q this cycle.
   always_comb begin
      vld_d    = vld_q;
      inv_d    = inv_q;
      adr_d    = adr_q;
      err_d    = err_q;
      fea_d    = fea_q;
      vld_d[0] = iss_vld;
      inv_d[0] = iss_inv;
      adr_d[0] = iss_addr;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         vld_d[i] = vld_q[i-1];
         inv_d[i] = inv_q[i-1];
         adr_d[i] = adr_q[i-1];
      end

      exp_word = DATA_WIDTH'(exp_pat(32'(adr_q[RD_LAT-1]), inv_q[RD_LAT-1], 32'(PAT_OFS)));
      mismatch = vld_q[RD_LAT-1] && (ram_q != exp_word);

      if (clr) begin
         err_d = '0;
         fea_d = '0;
      end else if (mismatch) begin
         // err_q only leaves zero on a mismatch and never wraps back, so zero
         // means no earlier mismatch in this run.
         if (err_q == '0) fea_d = adr_q[RD_LAT-1];
         if (err_q != '1) err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         inv_q <= '0;
         adr_q <= '0;
         err_q <= '0;
         fea_q <= '0;
      end else begin
         vld_q <= vld_d;
         inv_q <= inv_d;
         adr_q <= adr_d;
         err_q <= err_d;
         fea_q <= fea_d;
      end
   end

   assign err_cnt        = err_q;
   assign first_err_addr = fea_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - march-style write/read-back self test for a single-port RAM
//
// Purpose: on start, writes exp(a) to every address 0..DEPTH-1, reads them back and
//          reports pass/fail, mismatch count and first failing address.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (aborts a running test)
//   start           1-cycle request, honoured only in IDLE/DONE
//   busy            high from the cycle after start until done rises
//   done            level, high from test end until the next accepted start
//   pass            valid with done; 1 when err_cnt == 0
//   err_cnt         saturating mismatch count
//   first_err_addr  address of first mismatch, 0 if none
//   ram             RAM port bundle (ram_bist_if.master)
// Configuration:
//   RAM_BIST_INV_PASS_EN  adds a second write/read pass with ~exp(a) so every data
//                         bit is seen at both polarities

module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned PAT_OFS    = 1,
   parameter int unsigned ERR_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_cnt,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   ram_bist_if.master            ram
);

   // Terminal address compared at ADDR_WIDTH, so DEPTH == 2**ADDR_WIDTH never
   // relies on the counter overflowing.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   bist_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  we_q, we_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  rd_inv_q, rd_inv_d;
   logic [2:0]            drain_q, drain_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic                  clr;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic                  inv);
      return DATA_WIDTH'(exp_pat(32'(a), inv, 32'(PAT_OFS)));
   endfunction

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = 1'b0;
      rd_vld_d = 1'b0;
      rd_inv_d = rd_inv_q;
      drain_d  = drain_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      clr      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               clr     = 1'b1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               addr_d  = '0;
               we_d    = 1'b1;
               data_d  = pat('0, 1'b0);
               state_d = WRITE;
            end
         end

         WRITE: begin
            if (addr_q == LAST_ADDR) begin
               addr_d   = '0;
               rd_vld_d = 1'b1;
               rd_inv_d = 1'b0;
               state_d  = READ;
            end else begin
               addr_d = addr_q + 1'b1;
               we_d   = 1'b1;
               data_d = pat(addr_q + 1'b1, 1'b0);
            end
         end

         READ: begin
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
`ifdef RAM_BIST_INV_PASS_EN
               we_d    = 1'b1;
               data_d  = pat('0, 1'b1);
               state_d = WRITE_INV;
`else
               drain_d = '0;
               state_d = DRAIN;
`endif
            end else begin
               addr_d   = addr_q + 1'b1;
               rd_vld_d = 1'b1;
            end
         end

`ifdef RAM_BIST_INV_PASS_EN
         WRITE_INV: begin
            if (addr_q == LAST_ADDR) begin
               addr_d   = '0;
               rd_vld_d = 1'b1;
               rd_inv_d = 1'b1;
               state_d  = READ_INV;
            end else begin
               addr_d = addr_q + 1'b1;
               we_d   = 1'b1;
               data_d = pat(addr_q + 1'b1, 1'b1);
            end
         end

         READ_INV: begin
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               drain_d = '0;
               state_d = DRAIN;
            end else begin
               addr_d   = addr_q + 1'b1;
               rd_vld_d = 1'b1;
            end
         end
`endif

         DRAIN: begin
            // The last read's compare registers RD_LAT+1 clocks after it was
            // issued; pass is taken from err_cnt only once that has landed.
            if (drain_q == 3'(RD_LAT)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_cnt == '0);
               state_d = DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         rd_vld_q <= 1'b0;
         rd_inv_q <= 1'b0;
         drain_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         rd_vld_q <= rd_vld_d;
         rd_inv_q <= rd_inv_d;
         drain_q  <= drain_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   ram_bist_cmp #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LAT     (RD_LAT),
      .PAT_OFS    (PAT_OFS),
      .ERR_W      (ERR_W)
   ) u_cmp (
      .clk            (clk),
      .rst_n          (rst_n),
      .clr            (clr),
      .iss_vld        (rd_vld_q),
      .iss_inv        (rd_inv_q),
      .iss_addr       (addr_q),
      .ram_q          (ram.q),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr)
   );

   assign ram.addr = addr_q;
   assign ram.data = data_q;
   assign ram.we   = we_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;

endmodule
